addsub_seq: RTL and testbench

//  Multi-cycle, parametrised add/subtract unit for the ALU datapath, replacing the one-shot
//  XOR-complement + adder path. Computes A + (B^{W{inv}}) + cin one CHUNK slice per clock,

---
 rtl/addsub_seq_pkg.sv | 23 ++
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_chunk.sv | 26 ++
 rtl/addsub_seq.sv | 132 +++++++++++++
 tb/tb_addsub_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the sequential add/subtract unit.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_NEG  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Bit positions inside the {N,Z,C,V} flag vector.
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/addsub_seq_if.sv
// Valid/ready operand and result bus of the sequential add/subtract unit.
interface addsub_seq_if #(
   parameter int unsigned WIDTH = 32
);

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;

   // Producer of operands and consumer of results.
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   // The arithmetic unit itself.
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/addsub_chunk.sv
// One combinational slice of the adder: a + (b ^ inv) + cin, with slice-MSB overflow.
module addsub_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             inv,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             msb_v
);

   logic [CHUNK-1:0] beff;
   logic [CHUNK:0]   total;

   // Ripple add of the slice; msb_v is only meaningful on the top slice.
   always_comb begin
      beff  = b ^ {CHUNK{inv}};
      total = {1'b0, a} + {1'b0, beff} + {{CHUNK{1'b0}}, cin};
      sum   = total[CHUNK-1:0];
      cout  = total[CHUNK];
      msb_v = (a[CHUNK-1] == beff[CHUNK-1]) && (sum[CHUNK-1] != a[CHUNK-1]);
   end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: one CHUNK slice per clock, LSB first, NZCV at the end.
module addsub_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic        clk,
   input  logic        rst,
   addsub_seq_if.slave bus
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("addsub_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             inv_q, inv_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
   logic             sl_cout, sl_v;

   assign sl_a = a_q[idx_q*CHUNK +: CHUNK];
   assign sl_b = b_q[idx_q*CHUNK +: CHUNK];

   // carry_q is preloaded with cin at acceptance, so slice 0 sees cin.
   addsub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a     (sl_a),
      .b     (sl_b),
      .inv   (inv_q),
      .cin   (carry_q),
      .sum   (sl_sum),
      .cout  (sl_cout),
      .msb_v (sl_v)
   );

   // Next-state logic: capture in IDLE, one slice per RUN cycle, hold in DONE.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      inv_d    = inv_q;
      result_d = result_q;
      flags_d  = flags_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d    = op_e'(bus.op);
               // Zero A turns NEG into 0-B and PASS into 0+B.
               a_d     = ((op_d == OP_NEG) || (op_d == OP_PASS)) ? '0 : bus.a;
               b_d     = bus.b;
               inv_d   = (op_d == OP_SUB) || (op_d == OP_NEG);
               carry_d = inv_d;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*CHUNK +: CHUNK] = sl_sum;
            carry_d = sl_cout;
            if (idx_q == LAST_IDX) begin
               idx_d           = '0;
               state_d         = DONE;
               flags_d[FLAG_N] = result_d[WIDTH-1];
               flags_d[FLAG_Z] = (result_d == '0);
               flags_d[FLAG_C] = (op_q != OP_PASS) && sl_cout;
               flags_d[FLAG_V] = (op_q != OP_PASS) && sl_v;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         inv_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         inv_q    <= inv_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: directed corner cases plus randomized ops vs a model.
module tb_addsub_seq;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   addsub_seq_if #(.WIDTH(32)) bus ();
   addsub_seq_if #(.WIDTH(32)) bus32 ();

   addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   addsub_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clk (clk),
      .rst (rst),
      .bus (bus32)
   );

   // Reference: signed/unsigned integer arithmetic on wide integers.
   function automatic void model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] r, output logic [3:0] f);
      longint          sa, sb, s;
      longint unsigned ua, ub;
      logic            c, v;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = {32'd0, av};
      ub = {32'd0, bv};
      s  = 0;
      c  = 1'b0;
      r  = '0;
      case (o)
         2'b00: begin s = sa + sb; r = av + bv; c = (ua + ub) > 64'hFFFF_FFFF; end
         2'b01: begin s = sa - sb; r = av - bv; c = (ua >= ub); end
         2'b10: begin s = -sb;     r = -bv;     c = (ub == 0); end
         default: begin s = sb;    r = bv;      c = 1'b0; end
      endcase
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      f = {r[31], (r == 32'd0), c, v};
   endfunction

   // Issue one op, wait for out_valid (bounded), capture outputs, then retire it.
   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic [3:0] f, output int lat);
      @(negedge clk);
      bus.op       = o;
      bus.a        = av;
      bus.b        = bv;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op       = 2'($urandom_range(0, 3));
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = bus.result;
      f = bus.flags;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
      checks++; if (bus.flags !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6];
      logic [31:0] as  [6];
      logic [31:0] bs  [6];
      logic [31:0] ers [6];
      logic [3:0]  efs [6];
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      ops = '{OP_ADD, OP_SUB, OP_SUB, OP_NEG, OP_NEG, OP_PASS};
      as  = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
      bs  = '{32'h1, 32'd5, 32'd1, 32'h8000_0000, 32'd0, 32'd0};
      ers = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
      efs = '{4'b1001, 4'b0110, 4'b1000, 4'b1001, 4'b0110, 4'b0100};
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], r, f, lat);
         checks++; if (lat !== 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
         checks++; if (r !== ers[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, ers[i]); end
         checks++; if (f !== efs[i]) begin failures++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, efs[i]); end
      end
   endtask

   task automatic test_random();
      logic [31:0] corner [4];
      logic [1:0]  o;
      logic [31:0] av, bv, r, er;
      logic [3:0]  f, ef;
      int          lat;
      corner = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      for (int i = 0; i < 40; i++) begin
         o  = 2'($urandom_range(0, 3));
         av = $urandom;
         bv = $urandom;
         if ($urandom_range(0, 3) == 0) av = corner[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) bv = corner[$urandom_range(0, 3)];
         model(o, av, bv, er, ef);
         run_op(o, av, bv, r, f, lat);
         checks++; if (lat !== 4) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=4", i, lat); end
         checks++; if (r !== er) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, av, bv, r, er); end
         checks++; if (f !== ef) begin failures++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h got=%b exp=%b", i, o, av, bv, f, ef); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      bus.op       = OP_SUB;
      bus.a        = 32'd10;
      bus.b        = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
      @(negedge clk);
      bus.op       = OP_ADD;
      bus.a        = 32'd1;
      bus.b        = 32'd1;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_out_valid got=%b exp=1", c, bus.out_valid); end
         checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got=%b exp=0", c, bus.in_ready); end
         checks++; if (bus.result !== 32'd7) begin failures++; $display("FAIL bp%0d_result got=%h exp=7", c, bus.result); end
         checks++; if (bus.flags !== 4'b0010) begin failures++; $display("FAIL bp%0d_flags got=%b exp=0010", c, bus.flags); end
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_retire_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_retire_in_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_no_capture got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      @(negedge clk);
      bus.op       = OP_ADD;
      bus.a        = 32'h1111_1111;
      bus.b        = 32'h2222_2222;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus.result); end
      checks++; if (bus.flags !== 4'd0) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", bus.flags); end
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, r, f, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=4", lat); end
      checks++; if (r !== 32'd0) begin failures++; $display("FAIL rstmid_next_result got=%h exp=0", r); end
      checks++; if (f !== 4'b0110) begin failures++; $display("FAIL rstmid_next_flags got=%b exp=0110", f); end
   endtask

   task automatic test_chunk32();
      int lat;
      @(negedge clk);
      bus32.op       = OP_ADD;
      bus32.a        = 32'd3;
      bus32.b        = 32'd4;
      bus32.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      lat = 0;
      while (!bus32.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat !== 1) begin failures++; $display("FAIL c32_latency got=%0d exp=1", lat); end
      checks++; if (bus32.result !== 32'd7) begin failures++; $display("FAIL c32_result got=%h exp=7", bus32.result); end
      checks++; if (bus32.flags !== 4'b0000) begin failures++; $display("FAIL c32_flags got=%b exp=0000", bus32.flags); end
      @(negedge clk);
      bus32.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus32.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus.op          = 2'b00;
      bus.a           = '0;
      bus.b           = '0;
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b0;
      bus32.op        = 2'b00;
      bus32.a         = '0;
      bus32.b         = '0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_chunk32();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
